// File: rtl/gpio_irq.sv
// gpio_irq: bidirectional GPIO block with a small register file, input
// synchronisers and edge-triggered, write-one-to-clear interrupt status.
module gpio_irq #(
  parameter int NPINS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NPINS-1:0] data_write,
  output logic [NPINS-1:0] data_read,
  input  logic [3:0]       addr,
  input  logic             w_strobe,
  inout  wire  [NPINS-1:0] pins,
  output logic             irq
);

  localparam logic [3:0] A_OUT     = 4'd0;
  localparam logic [3:0] A_OE      = 4'd1;
  localparam logic [3:0] A_IN      = 4'd2;
  localparam logic [3:0] A_SET     = 4'd3;
  localparam logic [3:0] A_CLR     = 4'd4;
  localparam logic [3:0] A_TGL     = 4'd5;
  localparam logic [3:0] A_RISE_EN = 4'd6;
  localparam logic [3:0] A_FALL_EN = 4'd7;
  localparam logic [3:0] A_STATUS  = 4'd8;

  // Edges are ignored until the synchroniser and prev register hold real pad data.
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [NPINS-1:0] out_r, oe_r, rise_en_r, fall_en_r, status_r, prev_r;
  logic [NPINS-1:0] sync_r [SYNC_STAGES];
  logic [2:0]       arm_cnt_r;

  logic [NPINS-1:0] in_s, rise_s, fall_s, event_s, clr_mask_s;
  logic [NPINS-1:0] out_next_s, oe_next_s, rise_en_next_s, fall_en_next_s;
  logic [NPINS-1:0] status_next_s, rdata_s;
  logic             armed_s;

  // Pad drivers: each pin is driven only while its output enable is set.
  for (genvar i = 0; i < NPINS; i++) begin : g_pad
    assign pins[i] = oe_r[i] ? out_r[i] : 1'bz;
  end

  assign in_s    = sync_r[SYNC_STAGES-1];
  assign rise_s  = in_s & ~prev_r;
  assign fall_s  = ~in_s & prev_r;
  assign event_s = (rise_s & rise_en_r) | (fall_s & fall_en_r);
  assign armed_s = (arm_cnt_r == ARM_MAX);

  // Register-write decode and next-state for control and status registers.
  always_comb begin
    out_next_s     = out_r;
    oe_next_s      = oe_r;
    rise_en_next_s = rise_en_r;
    fall_en_next_s = fall_en_r;
    clr_mask_s     = {NPINS{1'b0}};
    if (w_strobe) begin
      case (addr)
        A_OUT:     out_next_s     = data_write;
        A_OE:      oe_next_s      = data_write;
        A_SET:     out_next_s     = out_r | data_write;
        A_CLR:     out_next_s     = out_r & ~data_write;
        A_TGL:     out_next_s     = out_r ^ data_write;
        A_RISE_EN: rise_en_next_s = data_write;
        A_FALL_EN: fall_en_next_s = data_write;
        A_STATUS:  clr_mask_s     = data_write;
        default:   clr_mask_s     = {NPINS{1'b0}};
      endcase
    end else begin
      clr_mask_s = {NPINS{1'b0}};
    end
    // A new event on the same cycle as a clear wins.
    if (armed_s) begin
      status_next_s = (status_r & ~clr_mask_s) | event_s;
    end else begin
      status_next_s = status_r & ~clr_mask_s;
    end
  end

  // Read-data mux; write-only and unmapped addresses read as zero.
  always_comb begin
    rdata_s = {NPINS{1'b0}};
    case (addr)
      A_OUT:     rdata_s = out_r;
      A_OE:      rdata_s = oe_r;
      A_IN:      rdata_s = in_s;
      A_RISE_EN: rdata_s = rise_en_r;
      A_FALL_EN: rdata_s = fall_en_r;
      A_STATUS:  rdata_s = status_r;
      default:   rdata_s = {NPINS{1'b0}};
    endcase
  end

  // Control/status registers plus registered read data and interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r     <= {NPINS{1'b0}};
      oe_r      <= {NPINS{1'b0}};
      rise_en_r <= {NPINS{1'b0}};
      fall_en_r <= {NPINS{1'b0}};
      status_r  <= {NPINS{1'b0}};
      data_read <= {NPINS{1'b0}};
      irq       <= 1'b0;
    end else begin
      out_r     <= out_next_s;
      oe_r      <= oe_next_s;
      rise_en_r <= rise_en_next_s;
      fall_en_r <= fall_en_next_s;
      status_r  <= status_next_s;
      data_read <= rdata_s;
      irq       <= |status_next_s;
    end
  end

  // Input synchroniser chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {NPINS{1'b0}};
      end
      prev_r <= {NPINS{1'b0}};
    end else begin
      sync_r[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= in_s;
    end
  end

  // Arm counter: saturates once the synchroniser has flushed post-reset data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_r <= 3'd0;
    end else if (!armed_s) begin
      arm_cnt_r <= arm_cnt_r + 3'd1;
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed self-checking bench for gpio_irq (NPINS=16, SYNC_STAGES=2).
module tb_gpio_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [3:0]  addr;
  logic        w_strobe;
  wire  [15:0] pins;
  logic        irq;

  logic [15:0] tb_en;
  logic [15:0] tb_val;

  int checks = 0;
  int errors = 0;

  gpio_irq #(.NPINS(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_write (data_write),
    .data_read  (data_read),
    .addr       (addr),
    .w_strobe   (w_strobe),
    .pins       (pins),
    .irq        (irq)
  );

  // Bench-side pad drivers, active per bit.
  for (genvar i = 0; i < 16; i++) begin : g_tb_pad
    assign pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    addr = a;
    data_write = d;
    w_strobe = 1'b1;
    tick();
    w_strobe = 1'b0;
    data_write = 16'h0000;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    addr = a;
    tick();
    check_eq(tag, data_read, exp);
  endtask

  initial begin
    reset = 1'b1;
    w_strobe = 1'b0;
    addr = 4'd0;
    data_write = 16'h0000;
    tb_en = 16'hFFFF;
    tb_val = 16'hFFFF;

    // Reset state with pads held high.
    ticks(3);
    check_eq("rst_data_read", data_read, 16'h0000);
    check_eq("rst_irq", {15'd0, irq}, 16'h0000);

    // Arm window: pads high through reset, rising enable written right away.
    reset = 1'b0;
    wr(4'd6, 16'hFFFF);
    ticks(5);
    check_eq("arm_irq", {15'd0, irq}, 16'h0000);
    rd_check("arm_status", 4'd8, 16'h0000);
    rd_check("arm_in", 4'd2, 16'hFFFF);
    wr(4'd6, 16'h0000);
    rd_check("rst_out", 4'd0, 16'h0000);
    rd_check("rst_oe", 4'd1, 16'h0000);
    rd_check("rst_fall_en", 4'd7, 16'h0000);
    tb_val = 16'h0000;
    ticks(4);

    // Output path: OUT/SET/CLR/TGL and pad drive.
    tb_en = 16'h0000;
    wr(4'd1, 16'hFFFF);
    wr(4'd0, 16'h00F0);
    wr(4'd3, 16'h0003);
    rd_check("out_after_set", 4'd0, 16'h00F3);
    wr(4'd4, 16'h0010);
    rd_check("out_after_clr", 4'd0, 16'h00E3);
    wr(4'd5, 16'h8001);
    rd_check("out_after_tgl", 4'd0, 16'h80E2);
    check_eq("pads_drive", pins, 16'h80E2);
    rd_check("rd_set_zero", 4'd3, 16'h0000);
    rd_check("rd_clr_zero", 4'd4, 16'h0000);
    rd_check("rd_tgl_zero", 4'd5, 16'h0000);
    ticks(3);
    rd_check("in_loopback", 4'd2, 16'h80E2);
    wr(4'd1, 16'h0000);
    tb_en = 16'hFFFF;
    tb_val = 16'h0000;
    wr(4'd0, 16'h0000);
    ticks(4);
    rd_check("no_spurious_status", 4'd8, 16'h0000);

    // Rising edge on pad0: latency and W1C.
    wr(4'd6, 16'h0001);
    addr = 4'd2;
    tb_val = 16'h0001;
    tick();
    check_eq("rise_e1_in", data_read, 16'h0000);
    check_eq("rise_e1_irq", {15'd0, irq}, 16'h0000);
    tick();
    check_eq("rise_e2_in", data_read, 16'h0000);
    check_eq("rise_e2_irq", {15'd0, irq}, 16'h0000);
    tick();
    check_eq("rise_e3_in", data_read, 16'h0001);
    check_eq("rise_e3_irq", {15'd0, irq}, 16'h0001);
    rd_check("rise_status", 4'd8, 16'h0001);
    wr(4'd8, 16'h0001);
    check_eq("w1c_irq", {15'd0, irq}, 16'h0000);
    rd_check("w1c_status", 4'd8, 16'h0000);

    // Falling edge on pad2, enable changes keep status, set beats clear.
    wr(4'd7, 16'h0004);
    tb_val = 16'h0005;
    ticks(4);
    rd_check("fall_none_on_rise", 4'd8, 16'h0000);
    tb_val = 16'h0001;
    ticks(4);
    rd_check("fall_status", 4'd8, 16'h0004);
    wr(4'd7, 16'h0000);
    rd_check("fall_en_chg_keep", 4'd8, 16'h0004);
    wr(4'd6, 16'h0000);
    rd_check("rise_en_chg_keep", 4'd8, 16'h0004);
    wr(4'd7, 16'h0004);
    wr(4'd8, 16'h0004);
    rd_check("fall_w1c", 4'd8, 16'h0000);
    tb_val = 16'h0005;
    ticks(4);
    tb_val = 16'h0001;
    ticks(2);
    wr(4'd8, 16'h0004);
    check_eq("set_dom_irq", {15'd0, irq}, 16'h0001);
    rd_check("set_dom_status", 4'd8, 16'h0004);
    wr(4'd8, 16'h0004);
    rd_check("set_dom_cleanup", 4'd8, 16'h0000);

    // Unmapped addresses and ignored writes.
    wr(4'd0, 16'h1234);
    for (int a = 9; a < 16; a++) begin
      rd_check($sformatf("unmapped_rd_%0d", a), 4'(a), 16'h0000);
    end
    wr(4'd12, 16'hFFFF);
    wr(4'd2, 16'hFFFF);
    rd_check("ign_out", 4'd0, 16'h1234);
    rd_check("ign_oe", 4'd1, 16'h0000);
    rd_check("ign_rise_en", 4'd6, 16'h0000);
    rd_check("ign_fall_en", 4'd7, 16'h0004);
    rd_check("ign_status", 4'd8, 16'h0000);

    // Asynchronous reset mid-cycle with STATUS=0x0101 and pads driven.
    wr(4'd7, 16'h0000);
    wr(4'd6, 16'h0101);
    tb_val = 16'h0000;
    ticks(4);
    tb_val = 16'h0101;
    ticks(4);
    rd_check("pre_rst_status", 4'd8, 16'h0101);
    check_eq("pre_rst_irq", {15'd0, irq}, 16'h0001);
    wr(4'd0, 16'hFFFF);
    tb_en = 16'h0000;
    wr(4'd1, 16'hFFFF);
    tick();
    check_eq("pre_rst_pads", pins, 16'hFFFF);
    #2;
    reset = 1'b1;
    tb_en = 16'hFFFF;
    tb_val = 16'h0000;
    #1;
    check_eq("async_rst_irq", {15'd0, irq}, 16'h0000);
    check_eq("async_rst_pads", pins, 16'h0000);
    check_eq("async_rst_rdata", data_read, 16'h0000);
    tick();
    reset = 1'b0;
    ticks(2);
    rd_check("post_rst_status", 4'd8, 16'h0000);
    rd_check("post_rst_out", 4'd0, 16'h0000);
    rd_check("post_rst_oe", 4'd1, 16'h0000);
    check_eq("post_rst_irq", {15'd0, irq}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
